// File: rtl/hex_display_pkg.sv
// Shared constants and types for the hex display pager: page geometry and the page slice helper.
package hex_display_pkg;

  localparam int unsigned NUM_PAGES = 4;
  localparam int unsigned PAGE_W    = 2;
  localparam int unsigned PAGE_BITS = 16;
  localparam int unsigned DATA_W    = 64;

  typedef logic [PAGE_W-1:0] page_t;

  function automatic logic [PAGE_BITS-1:0] page_slice(input logic [DATA_W-1:0] data,
                                                      input page_t             pg);
    return data[PAGE_BITS*pg +: PAGE_BITS];
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Push-button conditioner: 2-FF synchroniser, stable-level debounce counter and a registered
// rising-edge pulse on the debounced level.
module button_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise_pulse
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  logic            s1_q, s2_q;
  logic            db_q, db_d;
  logic            db_prev_q;
  logic            pulse_q, pulse_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  // The new level is accepted only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_comb begin
    db_d  = db_q;
    cnt_d = '0;
    if (s2_q != db_q) begin
      if (cnt_q == CntMax) begin
        db_d = s2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    pulse_d = db_q & ~db_prev_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      db_q      <= 1'b0;
      db_prev_q <= 1'b0;
      cnt_q     <= '0;
      pulse_q   <= 1'b0;
    end else begin
      s1_q      <= raw;
      s2_q      <= s1_q;
      db_q      <= db_d;
      db_prev_q <= db_q;
      cnt_q     <= cnt_d;
      pulse_q   <= pulse_d;
    end
  end

  assign level      = db_q;
  assign rise_pulse = pulse_q;

endmodule

// File: rtl/hex_display_pager.sv
// Snapshot a 64-bit debug value and show it one 16-bit page at a time, stepped by a button or a
// scroll timer. Define HEX_PAGER_LIVE_EN to track data_in continuously instead of on load.
module hex_display_pager
  import hex_display_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned SCROLL_CYCLES   = 50000000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_W-1:0]    data_in,
  input  logic                 load,
  input  logic                 btn_next,
  input  logic                 auto_en,
  output logic [PAGE_BITS-1:0] disp,
  output logic [PAGE_W-1:0]    page,
  output logic                 step_pulse
);

  localparam int unsigned TmrW = $clog2(SCROLL_CYCLES);
  localparam logic [TmrW-1:0] TmrMax = TmrW'(SCROLL_CYCLES - 1);

  logic [DATA_W-1:0] snap_q, snap_d;
  page_t             page_q, page_d;
  logic [TmrW-1:0]   timer_q, timer_d;
  logic              step;
  logic              tick;
  logic              unused_db_level;

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk       (clk),
    .reset     (reset),
    .raw       (btn_next),
    .level     (unused_db_level),
    .rise_pulse(step)
  );

  assign tick = auto_en && (timer_q == TmrMax);

  always_comb begin
    snap_d  = snap_q;
    page_d  = page_q;
    timer_d = timer_q;
`ifdef HEX_PAGER_LIVE_EN
    snap_d = data_in;
`else
    if (load) snap_d = data_in;
`endif
    // load outranks stepping: a coincident step or tick is dropped.
    if (load) begin
      page_d  = '0;
      timer_d = '0;
    end else begin
      if (step || tick) page_d = page_q + 1'b1;
      if (!auto_en || step || tick) begin
        timer_d = '0;
      end else begin
        timer_d = timer_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      snap_q  <= '0;
      page_q  <= '0;
      timer_q <= '0;
    end else begin
      snap_q  <= snap_d;
      page_q  <= page_d;
      timer_q <= timer_d;
    end
  end

  assign disp       = page_slice(snap_q, page_q);
  assign page       = page_q;
  assign step_pulse = step;

endmodule

// File: doc/hex_display_pager.md
Name: hex_display_pager

Overview:
- Upstream feeder for the 4-digit hex display decoder.
- Captures a 64-bit debug value (register, PC, ALU result) into a snapshot register.
- Presents it 16 bits (one page) at a time on `disp`, which drives the decoder's 16-bit input.
- Page advances on a debounced push-button or an optional auto-scroll timer.

Parameters:
- DEBOUNCE_CYCLES, 50000, consecutive stable cycles required to accept a new button level (1 ms at 50 MHz); must be >= 2.
- SCROLL_CYCLES, 50000000, auto-scroll period in clock cycles (1 s at 50 MHz); must be >= 2.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- data_in  input  64  value to display.
- load  input  1  capture data_in into snapshot.
- btn_next  input  1  raw asynchronous push-button, active-high.
- auto_en  input  1  enable auto-scroll.
- disp  output  16  current page of snapshot, to decoder.
- page  output  2  current page index (0 = bits 15:0 … 3 = bits 63:48).
- step_pulse  output  1  one-cycle pulse when a debounced press is accepted.

Behaviour:
- Clocking: one clock domain; all state changes on the rising edge of clk. Reset is synchronous, active-high.
- Reset: snapshot = 0, page = 0, disp = 16'h0000, step_pulse = 0; synchroniser, debounce state, debounce counter and scroll timer all 0.
- Reset mid-debounce or mid-scroll discards all partial counts.
- Snapshot:
  - On an edge with load = 1, snapshot <= data_in, page <= 0, scroll timer <= 0.
  - No other source changes the snapshot.
- disp: combinational mux of the registered snapshot by the registered page, i.e. `snapshot[16*page +: 16]`.
  - No extra latency beyond the registers.
  - disp reflects a load on the cycle after the load edge.
- Button path:
  - 2-FF synchroniser (s1, s2).
  - Debounce counter: increments while s2 != db_state; clears when they are equal.
  - When the counter = DEBOUNCE_CYCLES-1 and s2 still differs: db_state <= s2, counter <= 0.
  - db_prev <= db_state every cycle.
  - step_pulse = db_state & ~db_prev, registered so it is a clean one-cycle pulse.
  - Latency: a press held high from edge 0 raises step_pulse for the cycle after edge DEBOUNCE_CYCLES+3. page increments at edge DEBOUNCE_CYCLES+4.
  - Glitches shorter than DEBOUNCE_CYCLES produce no pulse.
  - Release produces no pulse.
  - Holding the button produces exactly one pulse.
- Page stepping:
  - page <= page+1 modulo 4 (3 -> 0 wraps) on step_pulse or on a scroll tick.
- Scroll timer:
  - While auto_en = 0, the timer is held at 0.
  - While auto_en = 1, it counts 0..SCROLL_CYCLES-1. At SCROLL_CYCLES-1 it issues a tick and returns to 0.
  - A step_pulse also resets the timer to 0, so a manual step restarts the period.
- Simultaneous events (priority): reset > load > (step_pulse | tick).
  - step_pulse and tick in the same cycle produce a single increment.
  - load on the same edge as a step or tick gives page = 0; the step is lost.
- Widths: counters sized with `$clog2` of their parameter; no overflow is possible, since counters never exceed parameter-1.

Optional Feature:
- Macro HEX_PAGER_LIVE_EN.
- Defined: snapshot <= data_in on every edge (live view). load only clears page and the scroll timer.
- Undefined: snapshot changes only on load, as above.
- Ports are identical in both builds.

Decomposition:
- Shared package `hex_display_pkg`:
  - NUM_PAGES = 4, PAGE_W = 2, PAGE_BITS = 16, DATA_W = 64.
  - Page-index typedef (2-bit logic).
- Sub-module `button_debounce` (clk, reset, raw, level, rise_pulse; parameter DEBOUNCE_CYCLES) contains the synchroniser, debounce counter and edge detect.
- Top module holds the snapshot, page counter, scroll timer and output mux.

Test Plan (DEBOUNCE_CYCLES=4, SCROLL_CYCLES=10):
- Reset then load data_in=64'h0123_4567_89AB_CDEF -> next cycle disp=16'hCDEF, page=0.
- Press btn_next high for 20 cycles -> exactly one step_pulse; page=1, disp=16'h89AB at edge 8 after press. Three more presses give pages 2, 3, 0 (disp 4567, 0123, CDEF).
- Bounce btn_next high 3 cycles / low 2 cycles, repeated 5 times, then low -> no step_pulse; page unchanged.
- auto_en=1 from page 0 -> page increments every 10 cycles, wraps 3->0 after 40 cycles. A press accepted mid-period restarts the 10-cycle period.
- load asserted on the same edge as a scroll tick with page=2 -> page=0, snapshot updated; assert reset mid-debounce (counter=2) -> all outputs 0, no later step_pulse.
- With HEX_PAGER_LIVE_EN defined: change data_in to 64'hFFFF_0000_FFFF_1234 with no load -> disp=16'h1234 the next cycle.
